// File: rtl/mem_access_fsm_pkg.sv
// Shared encodings for the MEM-stage access controller: FSM states, access size codes
// and a small helper that turns a size code into a byte count.
package mem_access_fsm_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'd0,
        MEM_ACCESS = 2'd1,
        MEM_DONE   = 2'd2
    } memState_t;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    function automatic int sizeBytes(input logic [1:0] size);
        return 1 << size;
    endfunction

endpackage

// File: rtl/mem_access_fsm_lane_align.sv
// Byte-lane steering shared by the store and load paths: lane select, store-data
// replication, load extraction with sign/zero extension, and the alignment check.
module mem_lane_align
    import mem_access_fsm_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int LANES  = DATA_W / 8,
    localparam int OFF_W  = $clog2(LANES)
) (
    input  logic [1:0]        i_size,
    input  logic [OFF_W-1:0]  i_offset,
    input  logic              i_signed,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [LANES-1:0]  o_sel,
    output logic [DATA_W-1:0] o_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_misaligned
);

    int                w_nbytes;
    logic [DATA_W-1:0] w_shifted;
    logic [LANES-1:0]  w_mask;
    logic              w_signBit;

    // An illegal dword on a 32-bit bus is clamped so lane indexing stays in range.
    assign w_nbytes  = (sizeBytes(i_size) > LANES) ? LANES : sizeBytes(i_size);
    assign w_shifted = i_rdata >> {i_offset, 3'b000};
    assign o_sel     = w_mask << i_offset;

    always_comb begin
        w_mask    = '0;
        o_wdata   = '0;
        o_rdata   = '0;
        w_signBit = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (i < w_nbytes) w_mask[i] = 1'b1;
            if (i == w_nbytes - 1) w_signBit = w_shifted[i*8+7];
            for (int j = 0; j < LANES; j++) begin
                if (j == (i & (w_nbytes - 1))) o_wdata[i*8 +: 8] = i_wdata[j*8 +: 8];
            end
        end
        for (int i = 0; i < LANES; i++) begin
            o_rdata[i*8 +: 8] = (i < w_nbytes) ? w_shifted[i*8 +: 8] : {8{w_signBit & i_signed}};
        end
    end

    always_comb begin
        o_misaligned = 1'b0;
        case (i_size)
            SZ_BYTE: o_misaligned = 1'b0;
            SZ_HALF: o_misaligned = i_offset[0];
            SZ_WORD: o_misaligned = |i_offset[1:0];
            default: o_misaligned = (LANES < 8) ? 1'b1 : |i_offset;
        endcase
    end

endmodule

// File: rtl/mem_access_fsm.sv
// MEM-stage RAM interface: handshake FSM (IDLE/ACCESS/DONE) with alignment checking,
// a bounded wait-state timeout and a registered, extended load result.
module mem_access_fsm
    import mem_access_fsm_pkg::*;
#(
    parameter  int ADDR_W  = 32,
    parameter  int DATA_W  = 32,
    parameter  int TIMEOUT = 16,
    localparam int LANES   = DATA_W / 8,
    localparam int OFF_W   = $clog2(LANES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              signed_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ready_i,
    output logic              mem_ce_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LANES-1:0]  mem_sel_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              done_o,
    output logic              err_align_o,
    output logic              err_timeout_o,
    output logic              stallreq_o
);

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    memState_t         r_state;
    memState_t         w_nextState;
    logic              r_we;
    logic              r_signed;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [7:0]        r_waitCnt;
    logic              r_errAlign;
    logic              r_errTimeout;
    logic [DATA_W-1:0] r_rdata;

    logic              w_isIdle;
    logic              w_isAccess;
    logic              w_start;
    logic              w_reject;
    logic              w_timeout;
    logic [1:0]        w_alignSize;
    logic [OFF_W-1:0]  w_alignOff;
    logic [LANES-1:0]  w_sel;
    logic [DATA_W-1:0] w_storeData;
    logic [DATA_W-1:0] w_loadData;
    logic              w_misaligned;

    assign w_isIdle   = (r_state == MEM_IDLE);
    assign w_isAccess = (r_state == MEM_ACCESS);

    // While idle the aligner vets the incoming request; afterwards it sees only the latched copy.
    assign w_alignSize = w_isIdle ? size_i : r_size;
    assign w_alignOff  = w_isIdle ? addr_i[OFF_W-1:0] : r_addr[OFF_W-1:0];

    mem_lane_align #(.DATA_W(DATA_W)) u_laneAlign (
        .i_size       (w_alignSize),
        .i_offset     (w_alignOff),
        .i_signed     (r_signed),
        .i_wdata      (r_wdata),
        .i_rdata      (mem_data_i),
        .o_sel        (w_sel),
        .o_wdata      (w_storeData),
        .o_rdata      (w_loadData),
        .o_misaligned (w_misaligned)
    );

    assign w_start   = w_isIdle & req_valid_i & ~w_misaligned;
    assign w_reject  = w_isIdle & req_valid_i & w_misaligned;
    assign w_timeout = w_isAccess & ~mem_ready_i & (r_waitCnt == LAST_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= MEM_IDLE;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        stallreq_o  = 1'b0;
        mem_ce_o    = 1'b0;
        mem_we_o    = 1'b0;
        done_o      = 1'b0;
        case (r_state)
            MEM_IDLE: begin
                stallreq_o = req_valid_i;
                if (req_valid_i) w_nextState = w_misaligned ? MEM_DONE : MEM_ACCESS;
            end
            MEM_ACCESS: begin
                stallreq_o = 1'b1;
                mem_ce_o   = 1'b1;
                mem_we_o   = r_we;
                if (mem_ready_i || w_timeout) w_nextState = MEM_DONE;
            end
            MEM_DONE: begin
                done_o      = 1'b1;
                w_nextState = MEM_IDLE;
            end
            default: w_nextState = MEM_IDLE;
        endcase
    end

    // Ready takes priority over timeout; error flags live only for the DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we         <= 1'b0;
            r_signed     <= 1'b0;
            r_size       <= SZ_BYTE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_waitCnt    <= '0;
            r_errAlign   <= 1'b0;
            r_errTimeout <= 1'b0;
            r_rdata      <= '0;
        end else begin
            if (w_start) begin
                r_we      <= we_i;
                r_signed  <= signed_i;
                r_size    <= size_i;
                r_addr    <= addr_i;
                r_wdata   <= wdata_i;
                r_waitCnt <= '0;
            end
            if (w_isAccess) r_waitCnt <= r_waitCnt + 8'd1;
            if (w_reject) begin
                r_errAlign <= 1'b1;
                r_rdata    <= '0;
            end
            if (w_isAccess && mem_ready_i) begin
                r_rdata <= r_we ? '0 : w_loadData;
            end else if (w_timeout) begin
                r_errTimeout <= 1'b1;
                r_rdata      <= '0;
            end
            if (r_state == MEM_DONE) begin
                r_errAlign   <= 1'b0;
                r_errTimeout <= 1'b0;
            end
        end
    end

    assign mem_addr_o    = w_isAccess ? {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign mem_sel_o     = w_isAccess ? w_sel : '0;
    assign mem_data_o    = (w_isAccess && r_we) ? w_storeData : '0;
    assign rdata_o       = r_rdata;
    assign err_align_o   = r_errAlign;
    assign err_timeout_o = r_errTimeout;

endmodule

// File: tb/tb_mem_access_fsm.sv
// Self-checking bench for mem_access_fsm: a 32-bit and a 64-bit instance driven by
// directed and random transactions, checked cycle by cycle against a byte-arithmetic model.
module tb_mem_access_fsm;
    import mem_access_fsm_pkg::*;

    localparam int TO32 = 4;
    localparam int TO64 = 6;

    logic        clk;
    logic        rst;
    logic        reqValid;
    logic        weIn;
    logic        signedIn;
    logic        memReady;
    logic [1:0]  sizeIn;
    logic [31:0] addrIn;
    logic [63:0] wdataIn;
    logic [63:0] memData;
    logic        dutSel;

    logic        ce32, we32, done32, errA32, errT32, stall32;
    logic [31:0] addr32, data32, rdata32;
    logic [3:0]  sel32;
    logic        ce64, we64, done64, errA64, errT64, stall64;
    logic [31:0] addr64;
    logic [63:0] data64, rdata64;
    logic [7:0]  sel64;

    logic        obsCe, obsWe, obsDone, obsErrA, obsErrT, obsStall;
    logic [31:0] obsAddr;
    logic [7:0]  obsSel;
    logic [63:0] obsData, obsRdata;

    int          checkCount = 0;
    int          failCount  = 0;
    logic [63:0] lastRdata32 = '0;
    logic [63:0] lastRdata64 = '0;

    mem_access_fsm #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO32)) dut32 (
        .clk(clk), .rst(rst), .req_valid_i(reqValid & ~dutSel), .we_i(weIn), .size_i(sizeIn),
        .signed_i(signedIn), .addr_i(addrIn), .wdata_i(wdataIn[31:0]), .mem_data_i(memData[31:0]),
        .mem_ready_i(memReady), .mem_ce_o(ce32), .mem_we_o(we32), .mem_addr_o(addr32),
        .mem_sel_o(sel32), .mem_data_o(data32), .rdata_o(rdata32), .done_o(done32),
        .err_align_o(errA32), .err_timeout_o(errT32), .stallreq_o(stall32)
    );

    mem_access_fsm #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(TO64)) dut64 (
        .clk(clk), .rst(rst), .req_valid_i(reqValid & dutSel), .we_i(weIn), .size_i(sizeIn),
        .signed_i(signedIn), .addr_i(addrIn), .wdata_i(wdataIn), .mem_data_i(memData),
        .mem_ready_i(memReady), .mem_ce_o(ce64), .mem_we_o(we64), .mem_addr_o(addr64),
        .mem_sel_o(sel64), .mem_data_o(data64), .rdata_o(rdata64), .done_o(done64),
        .err_align_o(errA64), .err_timeout_o(errT64), .stallreq_o(stall64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (dutSel) begin
            obsCe = ce64; obsWe = we64; obsDone = done64; obsErrA = errA64; obsErrT = errT64;
            obsStall = stall64; obsAddr = addr64; obsSel = sel64; obsData = data64; obsRdata = rdata64;
        end else begin
            obsCe = ce32; obsWe = we32; obsDone = done32; obsErrA = errA32; obsErrT = errT32;
            obsStall = stall32; obsAddr = addr32; obsSel = {4'b0, sel32};
            obsData = {32'b0, data32}; obsRdata = {32'b0, rdata32};
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference lane behaviour from plain byte arithmetic: nb bytes at offset off within a lanes-wide bus.
    function automatic void modelLanes(input int lanes, input logic [1:0] size, input logic [31:0] addr,
                                       input logic sgn, input logic [63:0] wdata, input logic [63:0] mdata,
                                       output logic mis, output logic [7:0] sel, output logic [63:0] repl,
                                       output logic [63:0] ld, output logic [31:0] alignedAddr);
        int nb = 1 << size;
        int off = int'(addr[2:0]) & (lanes - 1);
        logic [63:0] full = (lanes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        logic [63:0] bmask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (nb * 8)) - 64'd1);
        mis = (nb > lanes) || ((off % nb) != 0);
        sel = 8'(((1 << nb) - 1) << off);
        repl = '0;
        for (int k = 0; k < lanes / nb; k++) repl = repl | ((wdata & bmask) << (k * nb * 8));
        ld = (mdata >> (off * 8)) & bmask;
        if (sgn && (((ld >> (nb * 8 - 1)) & 64'd1) != 0)) ld = ld | ~bmask;
        ld = ld & full;
        alignedAddr = addr - 32'(off);
    endfunction

    task automatic scrambleInputs(input logic [63:0] full);
        weIn     = 1'($urandom);
        signedIn = 1'($urandom);
        sizeIn   = 2'($urandom);
        addrIn   = $urandom;
        wdataIn  = {$urandom, $urandom} & full;
    endtask

    // One complete request; waits = ACCESS cycles before ready (>= timeout means never ready).
    task automatic applyStimulus(input logic which, input logic we, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [63:0] wdata, input int waits,
                                 input logic fixData, input logic [63:0] mdata);
        int lanes = which ? 8 : 4;
        int to = which ? TO64 : TO32;
        logic [63:0] full = which ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        logic mis, dummyMis, gotReady, errT;
        logic [7:0] eSel;
        logic [63:0] eRepl, eLd, eRdata, prevRdata;
        logic [31:0] eAddr;
        gotReady = 1'b0;
        errT = 1'b0;
        eRdata = '0;
        prevRdata = which ? lastRdata64 : lastRdata32;
        modelLanes(lanes, size, addr, sgn, wdata & full, '0, mis, eSel, eRepl, eLd, eAddr);

        @(negedge clk);
        dutSel = which; reqValid = 1'b1; weIn = we; sizeIn = size; signedIn = sgn;
        addrIn = addr; wdataIn = wdata & full; memReady = 1'b0;
        #1;
        checkOutput("idle_stall", obsStall, 1);
        checkOutput("idle_ce", obsCe, 0);
        checkOutput("idle_done", obsDone, 0);
        checkOutput("idle_rdata_hold", obsRdata, prevRdata);
        @(posedge clk);

        if (!mis) begin
            for (int i = 0; i < to; i++) begin
                @(negedge clk);
                scrambleInputs(full);
                memData  = (fixData && (i == waits)) ? (mdata & full) : ({$urandom, $urandom} & full);
                memReady = (i == waits);
                #1;
                checkOutput("acc_ce", obsCe, 1);
                checkOutput("acc_we", obsWe, we);
                checkOutput("acc_addr", obsAddr, eAddr);
                checkOutput("acc_sel", obsSel, eSel);
                checkOutput("acc_data", obsData, we ? eRepl : 64'd0);
                checkOutput("acc_stall", obsStall, 1);
                checkOutput("acc_done", obsDone, 0);
                if (i == waits) begin
                    modelLanes(lanes, size, addr, sgn, wdata & full, memData, dummyMis, eSel, eRepl, eLd, eAddr);
                    eRdata = we ? 64'd0 : eLd;
                    gotReady = 1'b1;
                end else if (i == to - 1) begin
                    eRdata = '0;
                    errT = 1'b1;
                end
                @(posedge clk);
                if (gotReady || errT) break;
            end
        end

        @(negedge clk);
        memReady = 1'b0;
        #1;
        checkOutput("done_pulse", obsDone, 1);
        checkOutput("done_ce", obsCe, 0);
        checkOutput("done_we", obsWe, 0);
        checkOutput("done_stall", obsStall, 0);
        checkOutput("done_err_align", obsErrA, mis);
        checkOutput("done_err_timeout", obsErrT, errT);
        checkOutput("done_rdata", obsRdata, eRdata);
        if (which) lastRdata64 = eRdata;
        else       lastRdata32 = eRdata;
        @(posedge clk);

        @(negedge clk);
        #1;
        checkOutput("post_ce", obsCe, 0);
        checkOutput("post_done", obsDone, 0);
        checkOutput("post_err_align", obsErrA, 0);
        checkOutput("post_err_timeout", obsErrT, 0);
        checkOutput("post_rdata_hold", obsRdata, eRdata);
        reqValid = 1'b0;
    endtask

    initial begin
        logic        rWhich, rWe, rSgn;
        logic [1:0]  rSize;
        logic [31:0] rAddr;
        rst = 1'b1; reqValid = 1'b0; weIn = 1'b0; signedIn = 1'b0; memReady = 1'b0;
        sizeIn = SZ_BYTE; addrIn = '0; wdataIn = '0; memData = '0; dutSel = 1'b0;
        #3;
        for (int s = 0; s < 2; s++) begin
            dutSel = 1'(s);
            #1;
            checkOutput("rst_ce", obsCe, 0);
            checkOutput("rst_we", obsWe, 0);
            checkOutput("rst_addr", obsAddr, 0);
            checkOutput("rst_sel", obsSel, 0);
            checkOutput("rst_data", obsData, 0);
            checkOutput("rst_rdata", obsRdata, 0);
            checkOutput("rst_done", obsDone, 0);
            checkOutput("rst_errs", {obsErrA, obsErrT}, 0);
            checkOutput("rst_stall", obsStall, 0);
        end
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed transactions");
        applyStimulus(0, 1, SZ_BYTE,  0, 32'h1003, 64'hA5, 2, 0, '0);
        applyStimulus(0, 0, SZ_HALF,  1, 32'h2002, '0, 0, 1, 64'h8001_1234);
        applyStimulus(0, 0, SZ_HALF,  0, 32'h2002, '0, 0, 1, 64'h8001_1234);
        applyStimulus(0, 0, SZ_WORD,  0, 32'h3001, '0, 0, 0, '0);
        applyStimulus(0, 0, SZ_WORD,  0, 32'h3000, '0, 99, 0, '0);
        applyStimulus(0, 0, SZ_WORD,  1, 32'h3004, '0, TO32 - 1, 1, 64'hDEAD_BEEF);
        applyStimulus(1, 0, SZ_DWORD, 0, 32'h0008, '0, 0, 1, 64'h0123_4567_89AB_CDEF);
        applyStimulus(0, 0, SZ_DWORD, 0, 32'h0008, '0, 0, 0, '0);
        applyStimulus(1, 1, SZ_HALF,  0, 32'h0016, 64'h1234, 1, 0, '0);
        applyStimulus(1, 0, SZ_BYTE,  1, 32'h0107, '0, 99, 0, '0);

        $display("[TB] random transactions");
        for (int n = 0; n < 60; n++) begin
            rWhich = 1'($urandom);
            rWe    = 1'($urandom);
            rSgn   = 1'($urandom);
            rSize  = 2'($urandom);
            rAddr  = $urandom;
            if ($urandom_range(0, 1) == 1) rAddr = rAddr & ~(32'd7);
            applyStimulus(rWhich, rWe, rSize, rSgn, rAddr, {$urandom, $urandom},
                          int'($urandom_range(0, rWhich ? TO64 + 1 : TO32 + 1)), 0, '0);
        end

        $display("[TB] reset during a store access");
        applyStimulus(0, 0, SZ_WORD, 0, 32'h50, '0, 0, 1, 64'h1357_9BDF);
        @(negedge clk);
        dutSel = 1'b0; reqValid = 1'b1; weIn = 1'b1; sizeIn = SZ_WORD; signedIn = 1'b0;
        addrIn = 32'h40; wdataIn = 64'h0BAD_F00D; memReady = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("pre_rst_ce", obsCe, 1);
        checkOutput("pre_rst_we", obsWe, 1);
        #2;
        rst = 1'b1;
        reqValid = 1'b0;
        #1;
        checkOutput("async_rst_ce", obsCe, 0);
        checkOutput("async_rst_we", obsWe, 0);
        checkOutput("async_rst_stall", obsStall, 0);
        checkOutput("async_rst_rdata", obsRdata, 0);
        @(negedge clk);
        rst = 1'b0;
        lastRdata32 = '0;
        lastRdata64 = '0;
        applyStimulus(0, 0, SZ_BYTE, 1, 32'h0041, '0, 1, 1, 64'h0000_8000);

        $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
        $finish;
    end

endmodule
